// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
//   fetch_entry_t    : one buffered fetch, {pc, insn}
//   NOP_INSN         : instruction presented when the buffer is empty
//   DEFAULT_RESET_PC : default fetch address after reset
package fetch_pkg;

   localparam int unsigned XLEN = 32;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] insn;
   } fetch_entry_t;

   localparam logic [XLEN-1:0] NOP_INSN         = 32'h0000_0013;
   localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries with flush.
// Ports:
//   clk, reset    : clock, synchronous active-high reset
//   flush_i       : empty the FIFO; a same-cycle push/pop is discarded
//   push_i        : write push_data_i at the tail (caller guarantees room)
//   pop_i         : drop the head entry (caller guarantees non-empty)
//   head_o        : current head entry (valid when !empty_o)
//   empty_o       : FIFO holds no entries
//   count_o       : number of entries held
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   flush_i,
   input  logic                   push_i,
   input  fetch_entry_t           push_data_i,
   input  logic                   pop_i,
   output fetch_entry_t           head_o,
   output logic                   empty_o,
   output logic [$clog2(DEPTH):0] count_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   fetch_entry_t    mem_q [DEPTH];
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q,  count_d;

   // Pointer and occupancy next state; pointers wrap naturally (DEPTH is 2^AW)
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop_i)  rd_ptr_d = rd_ptr_q + AW'(1);
         count_d = count_q + CW'(push_i) - CW'(pop_i);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset; occupancy qualifies every read.
   // Push at full with a pop overwrites the slot being read out this cycle.
   always_ff @(posedge clk) begin
      if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign empty_o = (count_q == '0);
   assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues word reads to
// instruction memory under a credit limit, buffers responses and hands
// {insn, pc} to the hart. A redirect flushes buffered and in-flight fetches.
// Optional macro FETCH_ALIGN_CHECK_EN adds fetch_fault for misaligned
// redirect targets; without it the target's low two bits are cleared.
// Ports:
//   clk, reset                      : clock, synchronous active-high reset
//   imem_req_valid/ready/addr       : fetch request channel
//   imem_rsp_valid/data             : in-order response channel, never stalled
//   insn_valid/ready, insn, pc      : head of the instruction buffer
//   redirect_valid, redirect_pc     : flush and restart fetch at redirect_pc
//   fetch_fault (FETCH_ALIGN_CHECK_EN only) : misaligned redirect seen
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
   parameter int unsigned DEPTH    = 2
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        insn_valid,
   input  logic        insn_ready,
   output logic [31:0] insn,
   output logic [31:0] pc,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc
`ifdef FETCH_ALIGN_CHECK_EN
   ,
   output logic        fetch_fault
`endif
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;

   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [31:0]   resp_pc_q,  resp_pc_d;
   logic [CW-1:0] outstanding_q, outstanding_d;
   logic [CW-1:0] drop_q, drop_d;

   logic [CW-1:0] fifo_count;
   logic          fifo_empty;
   fetch_entry_t  fifo_head;
   fetch_entry_t  push_entry;
   logic [CW:0]   credit_used;
   logic          req_fire;
   logic          rsp_ok;
   logic          push;
   logic          pop;
   logic          req_block;
   logic [31:0]   target;

`ifdef FETCH_ALIGN_CHECK_EN
   logic fault_q, fault_d;

   // Misaligned targets are kept as-is; the fault blocks all fetching
   assign target      = redirect_pc;
   assign req_block   = fault_q;
   assign fetch_fault = fault_q;

   always_comb begin
      fault_d = fault_q;
      if (redirect_valid) fault_d = (redirect_pc[1:0] != 2'b00);
   end

   always_ff @(posedge clk) begin
      if (reset) fault_q <= 1'b0;
      else       fault_q <= fault_d;
   end
`else
   assign target    = redirect_pc & 32'hFFFF_FFFC;
   assign req_block = 1'b0;
`endif

   // Every request holds a buffer slot from issue until its entry is popped
   assign credit_used    = (CW+1)'(fifo_count) + (CW+1)'(outstanding_q);
   assign imem_req_valid = !reset && !redirect_valid && !req_block &&
                           (credit_used < (CW+1)'(DEPTH));
   assign imem_req_addr  = fetch_pc_q;
   assign req_fire       = imem_req_valid && imem_req_ready;

   // A response with nothing outstanding is a protocol error and is ignored
   assign rsp_ok = imem_rsp_valid && (outstanding_q != '0);
   assign push   = rsp_ok && (drop_q == '0) && !redirect_valid;
   assign pop    = insn_valid && insn_ready && !redirect_valid;

   assign push_entry.pc   = resp_pc_q;
   assign push_entry.insn = imem_rsp_data;

   fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk         (clk),
      .reset       (reset),
      .flush_i     (redirect_valid),
      .push_i      (push),
      .push_data_i (push_entry),
      .pop_i       (pop),
      .head_o      (fifo_head),
      .empty_o     (fifo_empty),
      .count_o     (fifo_count)
   );

   assign insn_valid = !fifo_empty;
   assign insn       = insn_valid ? fifo_head.insn : NOP_INSN;
   assign pc         = insn_valid ? fifo_head.pc   : 32'h0000_0000;

   // PC, credit and drop next state; redirect overrides everything else
   always_comb begin
      fetch_pc_d    = fetch_pc_q;
      resp_pc_d     = resp_pc_q;
      drop_d        = drop_q;
      outstanding_d = outstanding_q + CW'(req_fire) - CW'(rsp_ok);
      if (redirect_valid) begin
         fetch_pc_d = target;
         resp_pc_d  = target;
         // Everything still in flight after this edge belongs to the old stream
         drop_d     = outstanding_q - CW'(rsp_ok);
      end else begin
         if (req_fire) fetch_pc_d = fetch_pc_q + 32'd4;
         if (rsp_ok) begin
            if (drop_q != '0) drop_d    = drop_q - CW'(1);
            else              resp_pc_d = resp_pc_q + 32'd4;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc_q    <= RESET_PC;
         resp_pc_q     <= RESET_PC;
         outstanding_q <= '0;
         drop_q        <= '0;
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         resp_pc_q     <= resp_pc_d;
         outstanding_q <= outstanding_d;
         drop_q        <= drop_d;
      end
   end

`ifndef SYNTHESIS
   rsp_without_request : assert property (@(posedge clk) disable iff (reset)
      !(imem_rsp_valid && (outstanding_q == '0)));
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: an in-order memory with configurable latency and a
// queue/epoch reference model of the instruction stream the hart must see.
module tb_fetch_unit;
   import fetch_pkg::*;

   localparam int unsigned DEPTH   = 2;
   localparam logic [31:0] RST_PC  = 32'h0000_0000;
   localparam logic [31:0] XOR_PAT = 32'hA5A5_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        insn_valid;
   logic        insn_ready;
   logic [31:0] insn;
   logic [31:0] pc;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
`ifdef FETCH_ALIGN_CHECK_EN
   logic        fetch_fault;
`endif

   always #5 clk = ~clk;

   fetch_unit #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
      .clk            (clk),
      .reset          (reset),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .insn_valid     (insn_valid),
      .insn_ready     (insn_ready),
      .insn           (insn),
      .pc             (pc),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc)
`ifdef FETCH_ALIGN_CHECK_EN
      ,
      .fetch_fault    (fetch_fault)
`endif
   );

   typedef struct {
      logic [31:0] addr;
      int unsigned epoch;
      int unsigned due;
   } mreq_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] insn;
   } ent_t;

   // Memory in flight (also the outstanding count) and expected buffer contents
   mreq_t       memq[$];
   ent_t        mq[$];
   logic [31:0] popped[$];
   logic [31:0] fired[$];

   int unsigned epoch = 0;
   int unsigned cyc   = 0;
   int unsigned fires = 0;
   int unsigned lat   = 1;
   logic [31:0] next_req_pc = RST_PC;
   logic        m_fault = 1'b0;

   bit          reset_force   = 1'b1;
   bit          ready_rand    = 1'b0;
   bit          rand_redirect = 1'b0;
   bit          collide_mode  = 1'b0;
   bit          collided      = 1'b0;
   bit          pend_redirect = 1'b0;
   int          hart_mode     = 1;
   logic [31:0] pend_target   = '0;
   logic [31:0] collide_target = '0;

   logic        s_req_valid, s_insn_valid, s_fault;
   logic [31:0] s_req_addr, s_insn, s_pc;

   int tests = 0;
   int fails = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   // Drive inputs shortly after the rising edge
   task automatic drive();
      reset = reset_force;
      if (!reset_force && memq.size() > 0 && memq[0].due <= cyc) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = memq[0].addr ^ XOR_PAT;
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = $urandom;
      end
      imem_req_ready = ready_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      case (hart_mode)
         0:       insn_ready = 1'b0;
         1:       insn_ready = 1'b1;
         default: insn_ready = 1'($urandom_range(0, 1));
      endcase
      redirect_valid = 1'b0;
      redirect_pc    = $urandom;
      if (pend_redirect) begin
         redirect_valid = 1'b1;
         redirect_pc    = pend_target;
         pend_redirect  = 1'b0;
      end else if (collide_mode && imem_rsp_valid && insn_valid && insn_ready) begin
         redirect_valid = 1'b1;
         redirect_pc    = collide_target;
         collide_mode   = 1'b0;
         collided       = 1'b1;
      end else if (rand_redirect && $urandom_range(0, 19) == 0) begin
         redirect_valid = 1'b1;
         redirect_pc    = ($urandom_range(0, 7) == 0) ? 32'($urandom)
                                                      : (32'($urandom) & 32'hFFFF_FFFC);
      end
   endtask

   // Compare DUT outputs with the model on the falling edge
   task automatic compare();
      bit exp_rv;
      s_req_valid  = imem_req_valid;
      s_req_addr   = imem_req_addr;
      s_insn_valid = insn_valid;
      s_insn       = insn;
      s_pc         = pc;
      exp_rv = !reset && !redirect_valid && !m_fault &&
               ((mq.size() + memq.size()) < DEPTH);
      chk("req_valid", 32'(s_req_valid), 32'(exp_rv));
      if (exp_rv && s_req_valid) chk("req_addr", s_req_addr, next_req_pc);
      chk("insn_valid", 32'(s_insn_valid), 32'(mq.size() != 0));
      if (mq.size() != 0) begin
         chk("head_pc", s_pc, mq[0].pc);
         chk("head_insn", s_insn, mq[0].insn);
      end else begin
         chk("empty_insn", s_insn, NOP_INSN);
         chk("empty_pc", s_pc, 32'h0);
      end
`ifdef FETCH_ALIGN_CHECK_EN
      s_fault = fetch_fault;
      chk("fetch_fault", 32'(s_fault), 32'(m_fault));
`else
      s_fault = 1'b0;
`endif
   endtask

   // Advance the model across the rising edge using this cycle's inputs
   task automatic update();
      mreq_t       h;
      bit          have_rsp;
      logic [31:0] tgt;
      if (reset) begin
         mq.delete();
         memq.delete();
         epoch++;
         next_req_pc = RST_PC;
         m_fault     = 1'b0;
      end else begin
         have_rsp = imem_rsp_valid && memq.size() > 0;
         if (have_rsp) h = memq.pop_front();
         if (redirect_valid) begin
            mq.delete();
            epoch++;
`ifdef FETCH_ALIGN_CHECK_EN
            tgt     = redirect_pc;
            m_fault = (tgt[1:0] != 2'b00);
`else
            tgt     = {redirect_pc[31:2], 2'b00};
            m_fault = 1'b0;
`endif
            next_req_pc = tgt;
         end else begin
            if (s_insn_valid && insn_ready && mq.size() > 0) begin
               popped.push_back(mq[0].pc);
               void'(mq.pop_front());
            end
            // Responses from an older epoch were flushed by a redirect
            if (have_rsp && h.epoch == epoch)
               mq.push_back('{pc: h.addr, insn: h.addr ^ XOR_PAT});
            if (s_req_valid && imem_req_ready) begin
               memq.push_back('{addr: next_req_pc, epoch: epoch, due: cyc + lat});
               fired.push_back(s_req_addr);
               fires++;
               next_req_pc = next_req_pc + 32'd4;
            end
         end
      end
      cyc++;
   endtask

   task automatic step();
      drive();
      @(negedge clk);
      compare();
      @(posedge clk);
      update();
      #1;
   endtask

   task automatic do_reset(input int n);
      reset_force   = 1'b1;
      pend_redirect = 1'b0;
      collide_mode  = 1'b0;
      rand_redirect = 1'b0;
      ready_rand    = 1'b0;
      repeat (n) step();
      reset_force = 1'b0;
      popped.delete();
      fired.delete();
      fires = 0;
   endtask

   task automatic run_until_popped(input int n, input string name);
      int k = 0;
      while (popped.size() < n && k < 200) begin
         step();
         k++;
      end
      chk(name, 32'(popped.size() >= n), 32'd1);
   endtask

   initial begin
      reset          = 1'b1;
      imem_req_ready = 1'b1;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      insn_ready     = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      @(posedge clk);
      #1;

      // Latency and in-order stream from reset with a 1-cycle memory.
      // DEPTH=2 and a 3-cycle credit loop give 2 insns per 3 cycles.
      lat = 1; hart_mode = 1;
      do_reset(3);
      step();
      chk("t1_req_valid_N", 32'(s_req_valid), 32'd1);
      chk("t1_req_addr_N", s_req_addr, 32'h0);
      step();
      chk("t1_insn_valid_N1", 32'(s_insn_valid), 32'd0);
      step();
      chk("t1_insn_valid_N2", 32'(s_insn_valid), 32'd1);
      chk("t1_pc_N2", s_pc, 32'h0);
      chk("t1_insn_N2", s_insn, 32'hA5A5_0000);
      run_until_popped(4, "t1_timeout");
      chk("t1_pop0", popped[0], 32'h0);
      chk("t1_pop1", popped[1], 32'h4);
      chk("t1_pop2", popped[2], 32'h8);
      chk("t1_pop3", popped[3], 32'hC);

      // Hart stalled: buffer fills to DEPTH and requests stop
      do_reset(2);
      hart_mode = 0;
      repeat (10) step();
      chk("t2_fires", 32'(fires), 32'd2);
      chk("t2_buffered_valid", 32'(s_insn_valid), 32'd1);
      chk("t2_req_blocked", 32'(s_req_valid), 32'd0);
      hart_mode = 1;
      run_until_popped(4, "t2_timeout");
      chk("t2_pop0", popped[0], 32'h0);
      chk("t2_pop1", popped[1], 32'h4);
      chk("t2_pop3", popped[3], 32'hC);

      // Redirect with two requests in flight on a 3-cycle memory
      do_reset(2);
      lat = 3;
      begin
         int k = 0;
         while (memq.size() < 2 && k < 50) begin step(); k++; end
      end
      chk("t3_two_outstanding", 32'(memq.size()), 32'd2);
      pend_redirect = 1'b1; pend_target = 32'h100;
      popped.delete();
      run_until_popped(1, "t3_timeout");
      chk("t3_first_pc", popped[0], 32'h100);

      // Redirect coinciding with a response and a pop
      do_reset(2);
      lat = 1;
      collided = 1'b0; collide_mode = 1'b1; collide_target = 32'h400;
      begin
         int k = 0;
         while (!collided && k < 50) begin step(); k++; end
      end
      chk("t4_collided", 32'(collided), 32'd1);
      step();
      chk("t4_flushed", 32'(s_insn_valid), 32'd0);
      chk("t4_req_valid", 32'(s_req_valid), 32'd1);
      chk("t4_req_addr", s_req_addr, 32'h400);
      popped.delete();
      run_until_popped(1, "t4_timeout");
      chk("t4_first_pc", popped[0], 32'h400);

      // Fetch PC wraps past the top of the address space
      do_reset(2);
      pend_redirect = 1'b1; pend_target = 32'hFFFF_FFFC;
      begin
         int k = 0;
         while (fired.size() < 2 && k < 50) begin step(); k++; end
      end
      chk("t5_fire_count", 32'(fired.size() >= 2), 32'd1);
      chk("t5_addr0", fired[0], 32'hFFFF_FFFC);
      chk("t5_addr1", fired[1], 32'h0000_0000);

`ifdef FETCH_ALIGN_CHECK_EN
      // Misaligned redirect faults and blocks fetch until an aligned one
      do_reset(2);
      pend_redirect = 1'b1; pend_target = 32'h102;
      repeat (2) step();
      chk("t6_fault_set", 32'(s_fault), 32'd1);
      chk("t6_no_req", 32'(s_req_valid), 32'd0);
      repeat (5) step();
      pend_redirect = 1'b1; pend_target = 32'h200;
      repeat (2) step();
      chk("t6_fault_clear", 32'(s_fault), 32'd0);
      chk("t6_req_valid", 32'(s_req_valid), 32'd1);
      chk("t6_req_addr", s_req_addr, 32'h200);
`endif

      // Randomized traffic: latency, stalls, redirects and mid-run resets
      do_reset(2);
      ready_rand = 1'b1; hart_mode = 2; rand_redirect = 1'b1;
      for (int i = 0; i < 4000; i++) begin
         if (i % 250 == 0) lat = $urandom_range(1, 4);
         reset_force = (i % 1000 == 999);
         step();
      end
      reset_force = 1'b0; ready_rand = 1'b0; rand_redirect = 1'b0; hart_mode = 1;
      repeat (20) step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
